// File: rtl/hit_judge_pkg.sv
// Shared definitions for the hit judge: game-state encodings (shared with the
// score counter and top-level game FSM), lane FSM encodings, default limits
// and a small popcount helper for the 2-lane hit/miss vectors.
package hit_judge_pkg;

    // Game state as driven by the top-level game FSM.
    typedef enum logic [1:0] {
        GS_IDLE        = 2'd0,
        GS_SONG_SELECT = 2'd1,
        GS_GAME_PLAY   = 2'd2,
        GS_GAME_OVER   = 2'd3
    } game_state_e;

    // Per-lane judgment state.
    typedef enum logic {
        LANE_WAIT  = 1'b0,
        LANE_ARMED = 1'b1
    } lane_state_e;

    localparam int unsigned NUM_LANES            = 2;
    localparam int unsigned WINDOW_TICKS_DEFAULT = 8;
    localparam int unsigned COMBO_MAX_DEFAULT    = 255;
    localparam int unsigned MISS_MAX_DEFAULT     = 255;

    // Number of set bits in a 2-lane vector (0..2).
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/lane_judge.sv
// lane_judge: one lane of the hit judge.
//   - 2-FF synchronizer on the raw button plus a third flop for edge detect.
//   - WAIT/ARMED FSM with a tick-driven down-counting judgment window.
// Produces combinational judge decisions (hit_d_o / miss_d_o); the parent
// registers them so hit/miss pulses and combo updates share one edge.
// Optional macro: GHOST_PRESS_PENALTY_EN -- a press in WAIT is judged a miss.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   LANE_WAIT  | no note pending; presses ignored (or penalised)
//   LANE_ARMED | note at the hit line; window counts down on tick
module lane_judge
    import hit_judge_pkg::*;
#(
    parameter int unsigned WINDOW_TICKS = WINDOW_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic tick_i,
    input  logic note_arrive_i,
    input  logic btn_i,
    output logic hit_d_o,
    output logic miss_d_o
);

    localparam logic [7:0] WIN_LOAD = 8'(WINDOW_TICKS);

    logic        sync1_q, sync2_q, sync3_q;
    logic        press;
    lane_state_e state_q, state_d;
    logic [7:0]  win_cnt_q, win_cnt_d;

    // Button synchronizer and edge-detect history; runs in every game state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign press = sync2_q & ~sync3_q;

    // Lane state and window counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LANE_WAIT;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    // Judgment: next state, window count and the hit/miss decision.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        hit_d_o   = 1'b0;
        miss_d_o  = 1'b0;

        if (!active_i) begin
            // Outside play any pending window is dropped silently.
            state_d   = LANE_WAIT;
            win_cnt_d = '0;
        end else begin
            case (state_q)
                LANE_WAIT: begin
`ifdef GHOST_PRESS_PENALTY_EN
                    if (press) begin
                        miss_d_o = 1'b1;
                    end
`endif
                    if (note_arrive_i) begin
                        state_d   = LANE_ARMED;
                        win_cnt_d = WIN_LOAD;
                    end
                end
                LANE_ARMED: begin
                    // A press always judges the note already in the window,
                    // and beats an expiring tick in the same cycle.
                    if (press) begin
                        hit_d_o   = 1'b1;
                        state_d   = LANE_WAIT;
                        win_cnt_d = '0;
                    end else if (note_arrive_i) begin
                        miss_d_o = 1'b1;
                    end else if (tick_i) begin
                        if (win_cnt_q == 8'd1) begin
                            miss_d_o  = 1'b1;
                            state_d   = LANE_WAIT;
                            win_cnt_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q - 8'd1;
                        end
                    end
                    // A newly arriving note always gets a fresh window.
                    if (note_arrive_i) begin
                        state_d   = LANE_ARMED;
                        win_cnt_d = WIN_LOAD;
                    end
                end
                default: begin
                    state_d   = LANE_WAIT;
                    win_cnt_d = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hit_judge.sv
// hit_judge: turns lane buttons and note-arrival pulses into single-cycle
// hit/miss pulses for the score counter, plus combo, max_combo and
// miss_count tracking gated by the game state.
// Optional macro: GHOST_PRESS_PENALTY_EN (stray presses in WAIT become misses).
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int unsigned WINDOW_TICKS = WINDOW_TICKS_DEFAULT,
    parameter int unsigned COMBO_MAX    = COMBO_MAX_DEFAULT,
    parameter int unsigned MISS_MAX     = MISS_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] current_state,
    input  logic       tick,
    input  logic [1:0] note_arrive,
    input  logic [1:0] btn,
    output logic [1:0] hit,
    output logic [1:0] miss,
    output logic [7:0] combo,
    output logic [7:0] max_combo,
    output logic [7:0] miss_count
);

    localparam logic [8:0] COMBO_LIM = 9'(COMBO_MAX);
    localparam logic [8:0] MISS_LIM  = 9'(MISS_MAX);

    game_state_e gs;
    logic        in_play;
    logic        in_select;

    logic [1:0]  lane_hit, lane_miss;
    logic [1:0]  hit_q, hit_d;
    logic [1:0]  miss_q, miss_d;
    logic [7:0]  combo_q, combo_d;
    logic [7:0]  max_q, max_d;
    logic [7:0]  miss_cnt_q, miss_cnt_d;
    logic [8:0]  combo_sum;
    logic [8:0]  miss_sum;

    assign gs        = game_state_e'(current_state);
    assign in_play   = (gs == GS_GAME_PLAY);
    assign in_select = (gs == GS_SONG_SELECT);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_judge #(
            .WINDOW_TICKS (WINDOW_TICKS)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .active_i      (in_play),
            .tick_i        (tick),
            .note_arrive_i (note_arrive[i]),
            .btn_i         (btn[i]),
            .hit_d_o       (lane_hit[i]),
            .miss_d_o      (lane_miss[i])
        );
    end

    // Pulse gating and combo / max / miss accounting for the coming edge.
    always_comb begin
        hit_d      = 2'b00;
        miss_d     = 2'b00;
        combo_d    = combo_q;
        max_d      = max_q;
        miss_cnt_d = miss_cnt_q;
        combo_sum  = {1'b0, combo_q} + {7'd0, popcount2(lane_hit)};
        miss_sum   = {1'b0, miss_cnt_q} + {7'd0, popcount2(lane_miss)};

        if (in_select) begin
            combo_d    = '0;
            max_d      = '0;
            miss_cnt_d = '0;
        end else if (in_play) begin
            hit_d  = lane_hit;
            miss_d = lane_miss;
            // Any miss breaks the streak; hits in the same cycle don't count.
            if (|lane_miss) begin
                combo_d = '0;
            end else if (combo_sum > COMBO_LIM) begin
                combo_d = COMBO_LIM[7:0];
            end else begin
                combo_d = combo_sum[7:0];
            end
            if (combo_d > max_q) begin
                max_d = combo_d;
            end
            if (miss_sum > MISS_LIM) begin
                miss_cnt_d = MISS_LIM[7:0];
            end else begin
                miss_cnt_d = miss_sum[7:0];
            end
        end
    end

    // Output and tracking registers; pulses and counters move on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q      <= '0;
            miss_q     <= '0;
            combo_q    <= '0;
            max_q      <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            combo_q    <= combo_d;
            max_q      <= max_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit        = hit_q;
    assign miss       = miss_q;
    assign combo      = combo_q;
    assign max_combo  = max_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with WINDOW_TICKS=4. Inputs change and outputs
// are sampled 1ns after each rising clock edge.
module tb_hit_judge;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] current_state;
    logic       tick;
    logic [1:0] note_arrive;
    logic [1:0] btn;
    logic [1:0] hit;
    logic [1:0] miss;
    logic [7:0] combo;
    logic [7:0] max_combo;
    logic [7:0] miss_count;

    int checks   = 0;
    int failures = 0;

    hit_judge #(
        .WINDOW_TICKS (4),
        .COMBO_MAX    (255),
        .MISS_MAX     (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .current_state (current_state),
        .tick          (tick),
        .note_arrive   (note_arrive),
        .btn           (btn),
        .hit           (hit),
        .miss          (miss),
        .combo         (combo),
        .max_combo     (max_combo),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arrive(input logic [1:0] m);
        note_arrive = m;
        cyc(1);
        note_arrive = 2'b00;
    endtask

    task automatic tick_n(input int n);
        tick = 1'b1;
        cyc(n);
        tick = 1'b0;
    endtask

    // Ticks with a check each cycle that no pulse appears.
    task automatic tick_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            chk({tag, "_hit"}, {6'd0, hit}, 8'd0);
            chk({tag, "_miss"}, {6'd0, miss}, 8'd0);
        end
        tick = 1'b0;
    endtask

    // Arm lanes m, press them, no checks (used for building combo).
    task automatic quiet_hit(input logic [1:0] m);
        arrive(m);
        btn = m;
        cyc(3);
        btn = 2'b00;
        cyc(2);
    endtask

    // Press lanes m (already armed) and check the hit pulse and its combo.
    task automatic press_hit(input string tag, input logic [1:0] m, input logic [7:0] exp_combo);
        btn = m;
        cyc(3);
        chk({tag, "_hit"}, {6'd0, hit}, {6'd0, m});
        chk({tag, "_miss"}, {6'd0, miss}, 8'd0);
        chk({tag, "_combo"}, combo, exp_combo);
        btn = 2'b00;
        cyc(1);
        chk({tag, "_hit_end"}, {6'd0, hit}, 8'd0);
        cyc(1);
    endtask

    initial begin
        rst           = 1'b0;
        current_state = 2'd2;
        tick          = 1'b0;
        note_arrive   = 2'b00;
        btn           = 2'b00;
        cyc(3);
        chk("rst_hit", {6'd0, hit}, 8'd0);
        chk("rst_miss", {6'd0, miss}, 8'd0);
        chk("rst_combo", combo, 8'd0);
        chk("rst_max", max_combo, 8'd0);
        chk("rst_misscnt", miss_count, 8'd0);
        rst = 1'b1;
        cyc(1);

        // Lane 0 hit after two ticks.
        arrive(2'b01);
        tick_n(2);
        press_hit("t1", 2'b01, 8'd1);

        // Build combo to 7.
        repeat (3) quiet_hit(2'b11);
        chk("c7_combo", combo, 8'd7);
        chk("c7_max", max_combo, 8'd7);

        // Lane 1 window expires on the 4th tick.
        arrive(2'b10);
        tick_n(3);
        chk("exp_pre_miss", {6'd0, miss}, 8'd0);
        tick_n(1);
        chk("exp_miss", {6'd0, miss}, 8'd2);
        chk("exp_combo", combo, 8'd0);
        chk("exp_misscnt", miss_count, 8'd1);
        chk("exp_max", max_combo, 8'd7);
        cyc(1);
        chk("exp_miss_end", {6'd0, miss}, 8'd0);

        // Combo to 5, then a double hit -> 7.
        repeat (2) quiet_hit(2'b11);
        quiet_hit(2'b01);
        chk("c5_combo", combo, 8'd5);
        arrive(2'b11);
        press_hit("dbl", 2'b11, 8'd7);

        // Press and expiring tick together: hit wins.
        arrive(2'b01);
        tick_n(3);
        btn = 2'b01;
        cyc(2);
        tick_n(1);
        chk("tie_hit", {6'd0, hit}, 8'd1);
        chk("tie_miss", {6'd0, miss}, 8'd0);
        chk("tie_combo", combo, 8'd8);
        btn = 2'b00;
        cyc(2);

        // Saturation at 255.
        repeat (123) quiet_hit(2'b11);
        chk("c254_combo", combo, 8'd254);
        arrive(2'b11);
        press_hit("sat1", 2'b11, 8'd255);
        chk("sat1_max", max_combo, 8'd255);
        arrive(2'b11);
        press_hit("sat2", 2'b11, 8'd255);

        // Lane 0 hit and lane 1 miss on the same edge.
        arrive(2'b11);
        tick_n(3);
        btn = 2'b01;
        cyc(2);
        tick_n(1);
        chk("mix_hit", {6'd0, hit}, 8'd1);
        chk("mix_miss", {6'd0, miss}, 8'd2);
        chk("mix_combo", combo, 8'd0);
        chk("mix_misscnt", miss_count, 8'd2);
        chk("mix_max", max_combo, 8'd255);
        btn = 2'b00;
        cyc(2);

        // Song select clears everything.
        arrive(2'b01);
        tick_n(4);
        repeat (6) quiet_hit(2'b11);
        chk("pre_sel_combo", combo, 8'd12);
        chk("pre_sel_misscnt", miss_count, 8'd3);
        arrive(2'b01);
        current_state = 2'd1;
        cyc(1);
        chk("sel_combo", combo, 8'd0);
        chk("sel_max", max_combo, 8'd0);
        chk("sel_misscnt", miss_count, 8'd0);
        chk("sel_miss", {6'd0, miss}, 8'd0);
        current_state = 2'd2;
        cyc(1);
        tick_quiet("sel_disarm", 5);

        // IDLE: presses and arrivals do nothing, counters frozen.
        quiet_hit(2'b11);
        chk("pre_idle_combo", combo, 8'd2);
        current_state = 2'd0;
        arrive(2'b11);
        btn = 2'b11;
        cyc(3);
        chk("idle_hit", {6'd0, hit}, 8'd0);
        chk("idle_miss", {6'd0, miss}, 8'd0);
        btn = 2'b00;
        cyc(2);
        tick_quiet("idle", 5);
        chk("idle_combo", combo, 8'd2);
        chk("idle_max", max_combo, 8'd2);

        // Leaving play while armed: window dropped, no miss.
        current_state = 2'd2;
        arrive(2'b01);
        current_state = 2'd3;
        tick_quiet("over", 5);
        chk("over_misscnt", miss_count, 8'd0);
        current_state = 2'd2;
        cyc(1);

        // Stray press in WAIT.
        btn = 2'b01;
        cyc(3);
        chk("stray_hit", {6'd0, hit}, 8'd0);
`ifdef GHOST_PRESS_PENALTY_EN
        chk("stray_miss", {6'd0, miss}, 8'd1);
        chk("stray_combo", combo, 8'd0);
        chk("stray_misscnt", miss_count, 8'd1);
`else
        chk("stray_miss", {6'd0, miss}, 8'd0);
        chk("stray_combo", combo, 8'd2);
        chk("stray_misscnt", miss_count, 8'd0);
`endif
        btn = 2'b00;
        cyc(2);

        // Reset in the middle of a window.
        quiet_hit(2'b11);
`ifdef GHOST_PRESS_PENALTY_EN
        chk("pre_rst_combo", combo, 8'd2);
`else
        chk("pre_rst_combo", combo, 8'd4);
`endif
        arrive(2'b01);
        tick_n(2);
        rst = 1'b0;
        #1;
        chk("mid_rst_hit", {6'd0, hit}, 8'd0);
        chk("mid_rst_miss", {6'd0, miss}, 8'd0);
        chk("mid_rst_combo", combo, 8'd0);
        chk("mid_rst_max", max_combo, 8'd0);
        chk("mid_rst_misscnt", miss_count, 8'd0);
        cyc(2);
        rst = 1'b1;
        tick_quiet("post_rst", 6);
        chk("post_rst_misscnt", miss_count, 8'd0);
        chk("post_rst_combo", combo, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Sits directly upstream of the score counter.
- Converts raw lane buttons and note-arrival pulses into a per-cycle hit vector (drives the score counter's 2-bit Inp) and a running combo count (drives its combo input).
- One judge per lane, a timing window per note, and a shared combo tracker gated by the game state.
- Hit outputs are single-cycle pulses, so the score counter adds exactly once per judged note.

Parameters:
- WINDOW_TICKS, 8, judgment window length in tick strobes after a note reaches the hit line (legal 1..255).
- COMBO_MAX, 255, saturation value for combo and max_combo.
- MISS_MAX, 255, saturation value for miss_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- current_state  in  2  game state: 0 IDLE, 1 SONG_SELECT, 2 GAME_PLAY, 3 GAME_OVER.
- tick  in  1  one-cycle timing strobe, window time base.
- note_arrive  in  2  one-cycle pulse per lane: a note reached the hit line.
- btn  in  2  raw asynchronous lane buttons, active-high.
- hit  out  2  one-cycle pulse per lane: note judged hit (to score Inp).
- miss  out  2  one-cycle pulse per lane: note judged missed.
- combo  out  8  current consecutive-hit count.
- max_combo  out  8  highest combo reached this song.
- miss_count  out  8  misses this song.

Behaviour:
- Reset (rst=0, async): all outputs 0, lanes WAIT, window counters 0, synchronizers 0.
- Button path, per lane:
  - 2-FF synchronizer, then rising-edge detect (press = sync2 & ~sync3).
  - Latency: hit pulse appears on the 3rd rising clk edge after btn is first sampled high.
- Lane FSM, states WAIT and ARMED:
  - WAIT + note_arrive -> ARMED, win_cnt <= WINDOW_TICKS.
  - ARMED + press -> hit pulse, -> WAIT.
  - ARMED + tick with win_cnt==1 -> miss pulse, -> WAIT. Otherwise tick decrements win_cnt.
  - ARMED + note_arrive (no press): previous note -> miss pulse; stay ARMED, win_cnt reloaded.
  - ARMED + note_arrive + press in the same cycle: press judges the old note (hit); the window reloads for the new note.
  - Press and expiring tick in the same cycle: hit wins.
  - Press in WAIT: ignored (see optional feature).
- Combo update, registered, same edge as the hit/miss pulses:
  - Any miss bit set this cycle: combo <= 0; hits in that same cycle are discarded from combo.
  - Otherwise: combo <= min(combo + popcount(hit), COMBO_MAX). Two simultaneous hits add 2.
  - max_combo <= max(max_combo, new combo).
  - miss_count += popcount(miss), saturating at MISS_MAX.
- State gating:
  - GAME_PLAY: fully active.
  - SONG_SELECT: synchronous clear of combo, max_combo, miss_count and lane FSMs; hit/miss held 0.
  - IDLE / GAME_OVER: lanes forced to WAIT, hit/miss 0, counters frozen.
  - Leaving GAME_PLAY while ARMED: window discarded, no miss generated.
- Mid-operation reset: async clear, no pulse emitted on reset release.

Optional Feature:
- Macro GHOST_PRESS_PENALTY_EN.
- Defined: a press while the lane is in WAIT during GAME_PLAY emits a miss pulse for that lane and breaks combo, with identical combo and miss_count effects.
- Undefined: stray presses are ignored.

Decomposition:
- Shared package hit_judge_pkg: game-state encodings (IDLE, SONG_SELECT, GAME_PLAY, GAME_OVER), shared with the score counter and top FSM; lane FSM state encodings; default WINDOW_TICKS.
- One sub-module: lane_judge (synchronizer, edge detect, WAIT/ARMED FSM, window counter), instantiated twice.
- Combo, max and miss tracking stay in hit_judge.

Test Plan:
- GAME_PLAY, WINDOW_TICKS=4: note_arrive[0], press after 2 ticks -> hit=01 for 1 cycle, combo 0->1; no miss.
- note_arrive[1], no press, 4 ticks -> miss=10 on the 4th tick edge, combo 7->0, miss_count +1, max_combo stays 7.
- Both lanes armed, both pressed in the same cycle -> hit=11 once, combo 5->7; press and expiring tick together -> hit, not miss.
- combo=254, two simultaneous hits -> combo=255 (saturated), max_combo=255; lane 0 hit and lane 1 miss in the same cycle -> combo=0.
- Switch to SONG_SELECT with combo=12, miss_count=3 -> all cleared next edge; IDLE with presses -> no pulses; rst low mid-window -> all outputs 0 immediately, no pulse after release.
- Stray press in WAIT -> no effect; with GHOST_PRESS_PENALTY_EN -> miss pulse, combo 0.
